// File: rtl/gpu_pkg.sv
// Shared GPU types and constants for the VRAM write path.
// VRAM_ADDR_WIDTH sets the VRAM address width and defaults to 10 bits.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

package gpu_pkg;

   localparam int unsigned VRAM_ADDR_W   = `VRAM_ADDR_WIDTH;
   localparam int unsigned DEFAULT_DEPTH = 16;

   // One buffered CPU write.
   typedef struct packed {
      logic [VRAM_ADDR_W-1:0] addr;
      logic [7:0]             data;
   } vram_wr_t;

   // Scheduler state: hold writes, or release them during the window.
   typedef enum logic {
      ST_WAIT  = 1'b0,
      ST_DRAIN = 1'b1
   } sched_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Circular write buffer for the VRAM write scheduler.
// It holds the storage, both pointers, the occupancy count and the full/empty flags.
// flush overrides push and pop. The caller must not pop when empty, and must not
// push when full unless it pops in the same cycle.
module vram_wr_fifo
   import gpu_pkg::*;
#(
   parameter  int unsigned DEPTH = DEFAULT_DEPTH,
   parameter  int unsigned W     = VRAM_ADDR_W + 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [W-1:0]     wdata,
   output logic [W-1:0]     rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   // Pointer and occupancy update. The pointers are log2(DEPTH) bits wide, so they wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_q <= count_q + CNT_W'(1);
         else if (pop && !push) count_q <= count_q - CNT_W'(1);
      end
   end

   // Storage write. The storage has no reset because the empty flag masks any stale entries.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr_q] <= wdata;
   end

   assign rdata = mem[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/vram_write_scheduler.sv
// VRAM write scheduler.
// It queues CPU writes and releases them one per clock, only while the video timing
// reports the VRAM-writable window.
// When VRAM_WRITE_BYPASS_EN is defined, a write that arrives while draining with an
// empty queue goes straight to the VRAM port in the same cycle.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

module vram_write_scheduler
   import gpu_pkg::*;
#(
   parameter  int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter  int unsigned ADDR_W = `VRAM_ADDR_WIDTH,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              writable,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_data,
   input  logic              flush,
   input  logic              clr_overflow,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_data,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic [CNT_W-1:0]  fifo_count,
   output logic              overflow,
   output logic              drain_done
);

   sched_state_e        state_q, state_d;
   logic                overflow_q, drain_done_q;
   logic                push, pop, drop, bypass;
   logic [ADDR_W+7:0]   head;

   vram_wr_fifo #(
      .DEPTH (DEPTH),
      .W     (ADDR_W + 8)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata ({cpu_addr, cpu_data}),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Qualify pop, push, drop and bypass. flush cancels all of them in the same cycle.
   always_comb begin
      pop = (state_q == ST_DRAIN) && writable && !fifo_empty && !flush;
`ifdef VRAM_WRITE_BYPASS_EN
      bypass = (state_q == ST_DRAIN) && writable && fifo_empty && cpu_we && !flush;
`else
      bypass = 1'b0;
`endif
      push = cpu_we && !flush && !bypass && (!fifo_full || pop);
      drop = cpu_we && !flush && fifo_full && !pop;
   end

   // Window tracking: drain only after the window has been seen high for one edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT:  if (writable)  state_d = ST_DRAIN;
         ST_DRAIN: if (!writable) state_d = ST_WAIT;
         default:                 state_d = ST_WAIT;
      endcase
   end

   // State, sticky overflow (set beats clear), and the drain-done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_WAIT;
         overflow_q   <= 1'b0;
         drain_done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (drop)              overflow_q <= 1'b1;
         else if (clr_overflow) overflow_q <= 1'b0;
         drain_done_q <= pop && !push && (fifo_count == CNT_W'(1));
      end
   end

   // VRAM port: the bypassed write, else the queue head, else zero while empty.
   always_comb begin
      vram_we = pop || bypass;
      if (bypass) begin
         vram_addr = cpu_addr;
         vram_data = cpu_data;
      end else if (!fifo_empty) begin
         vram_addr = head[ADDR_W+7:8];
         vram_data = head[7:0];
      end else begin
         vram_addr = '0;
         vram_data = '0;
      end
   end

   assign overflow   = overflow_q;
   assign drain_done = drain_done_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Self-checking bench for vram_write_scheduler: directed scenarios plus random traffic,
// checked against a queue-based model of the scheduling rules.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

module tb_vram_write_scheduler;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = `VRAM_ADDR_WIDTH;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              writable, cpu_we, flush, clr_overflow;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_data;
   logic              vram_we, fifo_full, fifo_empty, overflow, drain_done;
   logic [ADDR_W-1:0] vram_addr;
   logic [7:0]        vram_data;
   logic [CNT_W-1:0]  fifo_count;

   vram_write_scheduler #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .writable     (writable),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_data     (cpu_data),
      .flush        (flush),
      .clr_overflow (clr_overflow),
      .vram_we      (vram_we),
      .vram_addr    (vram_addr),
      .vram_data    (vram_data),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .drain_done   (drain_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [7:0]        d;
   } ent_t;

   // Reference model: queued writes, window seen on the last edge, sticky flags.
   ent_t q[$];
   bit   m_drain;
   bit   m_ovf;
   bit   m_dd;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int we_seen, dd_seen;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_drain = 0;
      m_ovf   = 0;
      m_dd    = 0;
   endtask

   // Drive one cycle, check outputs at the falling edge, then advance the model at the rising edge.
   task automatic step(input bit wr, input bit we, input logic [ADDR_W-1:0] a,
                       input logic [7:0] d, input bit fl, input bit clr);
      bit                pop_m, byp_m, push_m, drop_m, dd_next;
      logic [ADDR_W-1:0] exp_a;
      logic [7:0]        exp_d;
      ent_t              e;
      writable     = wr;
      cpu_we       = we;
      cpu_addr     = a;
      cpu_data     = d;
      flush        = fl;
      clr_overflow = clr;
      pop_m = m_drain && wr && (q.size() > 0) && !fl;
`ifdef VRAM_WRITE_BYPASS_EN
      byp_m = m_drain && wr && (q.size() == 0) && we && !fl;
`else
      byp_m = 0;
`endif
      push_m = we && !fl && !byp_m && ((q.size() < DEPTH) || pop_m);
      drop_m = we && !fl && (q.size() == DEPTH) && !pop_m;
      if (byp_m) begin
         exp_a = a;
         exp_d = d;
      end else if (q.size() > 0) begin
         exp_a = q[0].a;
         exp_d = q[0].d;
      end else begin
         exp_a = '0;
         exp_d = '0;
      end
      @(negedge clk);
      check_eq("vram_we", 32'(vram_we), 32'(pop_m || byp_m));
      check_eq("vram_addr", 32'(vram_addr), 32'(exp_a));
      check_eq("vram_data", 32'(vram_data), 32'(exp_d));
      check_eq("fifo_count", 32'(fifo_count), 32'(q.size()));
      check_eq("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
      check_eq("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
      check_eq("overflow", 32'(overflow), 32'(m_ovf));
      check_eq("drain_done", 32'(drain_done), 32'(m_dd));
      if (vram_we) we_seen++;
      if (drain_done) dd_seen++;
      @(posedge clk);
      dd_next = pop_m && !push_m && (q.size() == 1);
      e.a = a;
      e.d = d;
      if (fl) q.delete();
      else begin
         if (pop_m) void'(q.pop_front());
         if (push_m) q.push_back(e);
      end
      if (drop_m) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_dd    = dd_next;
      m_drain = wr;
      cyc++;
      #1;
   endtask

   initial begin
      bit wr_r;
      rst_n = 1'b0;
      writable = 0; cpu_we = 0; flush = 0; clr_overflow = 0;
      cpu_addr = '0; cpu_data = '0;
      model_reset();
      #2;
      check_eq("rst_vram_we", 32'(vram_we), 32'd0);
      check_eq("rst_count", 32'(fifo_count), 32'd0);
      check_eq("rst_empty", 32'(fifo_empty), 32'd1);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_drain_done", 32'(drain_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Writes outside the window are held, then drain in order when the window opens.
      step(0, 1, 10'h010, 8'hAA, 0, 0);
      step(0, 1, 10'h011, 8'hBB, 0, 0);
      we_seen = 0;
      step(0, 0, '0, '0, 0, 0);
      check_eq("s1_held_count", 32'(fifo_count), 32'd2);
      check_eq("s1_no_we", 32'(we_seen), 32'd0);
      dd_seen = 0;
      repeat (5) step(1, 0, '0, '0, 0, 0);
      check_eq("s1_we_cycles", 32'(we_seen), 32'd2);
      check_eq("s1_drain_done", 32'(dd_seen), 32'd1);
      check_eq("s1_count", 32'(fifo_count), 32'd0);

      // Overflow: the 17th write is dropped, and clearing the flag leaves the queue intact.
      for (int i = 0; i < 17; i++) step(0, 1, ADDR_W'(i), 8'($urandom), 0, 0);
      step(0, 0, '0, '0, 0, 0);
      check_eq("s2_overflow", 32'(overflow), 32'd1);
      check_eq("s2_full", 32'(fifo_full), 32'd1);
      step(0, 0, '0, '0, 0, 1);
      step(0, 0, '0, '0, 0, 0);
      check_eq("s2_cleared", 32'(overflow), 32'd0);
      check_eq("s2_count", 32'(fifo_count), 32'd16);

      // Window closes mid-drain. The first high cycle only enters DRAIN, so the next five cycles pop.
      we_seen = 0;
      repeat (6) step(1, 0, '0, '0, 0, 0);
      step(0, 0, '0, '0, 0, 0);
      check_eq("s3_pops", 32'(we_seen), 32'd5);
      check_eq("s3_count", 32'(fifo_count), 32'd11);

      // Full queue, with a push and a pop in the same cycle.
      for (int i = 0; i < 5; i++) step(0, 1, ADDR_W'(10'h100 + i), 8'(i), 0, 0);
      step(1, 0, '0, '0, 0, 0);
      step(1, 1, 10'h2AB, 8'hC3, 0, 0);
      step(1, 0, '0, '0, 0, 0);
      check_eq("s4_no_overflow", 32'(overflow), 32'd0);

      // Flush together with a write: the write is discarded and nothing goes to VRAM.
      step(1, 1, 10'h055, 8'h66, 1, 0);
      step(1, 0, '0, '0, 0, 0);
      check_eq("s5_flush_count", 32'(fifo_count), 32'd0);

      // A write while draining an empty queue: issued the same cycle with bypass, else one cycle later.
      step(1, 1, 10'h3FF, 8'h55, 0, 0);
      step(1, 0, '0, '0, 0, 0);
      step(1, 0, '0, '0, 0, 0);
      check_eq("s6_count", 32'(fifo_count), 32'd0);

      // Random traffic with window runs.
      wr_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) wr_r = !wr_r;
         step(wr_r, ($urandom_range(9) < 6), ADDR_W'($urandom), 8'($urandom),
              ($urandom_range(59) == 0), ($urandom_range(24) == 0));
      end

      // Asynchronous reset in the middle of a drain.
      for (int i = 0; i < 6; i++) step(0, 1, ADDR_W'(i), 8'(i), 0, 0);
      step(1, 0, '0, '0, 0, 0);
      writable = 1; cpu_we = 0; flush = 0; clr_overflow = 0;
      @(negedge clk);
      check_eq("pre_rst_we", 32'(vram_we), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_we", 32'(vram_we), 32'd0);
      check_eq("async_rst_count", 32'(fifo_count), 32'd0);
      check_eq("async_rst_empty", 32'(fifo_empty), 32'd1);
      check_eq("async_rst_overflow", 32'(overflow), 32'd0);
      check_eq("async_rst_addr", 32'(vram_addr), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, 0, '0, '0, 0, 0);
      step(1, 1, 10'h123, 8'h45, 0, 0);
      step(1, 0, '0, '0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
